// File: rtl/cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_miss_ctrl
// Brief    : Miss-handling sequencer for a 2-way write-back data cache.
//            Latches a CPU access, strobes the tag lookup, stalls on a miss,
//            writes back a dirty victim, refills the line and replays the
//            lookup. Keeps saturating hit/miss/write-back counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache_miss_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic                  Hit,
    input  logic                  VictimDirty,
    input  logic [DATA_WIDTH-1:0] VictimAddr,
    input  logic                  MemReady,
    output logic                  Stall,
    output logic                  CacheRdEn,
    output logic                  CacheWrEn,
    output logic                  CacheFill,
    output logic                  MemReqRead,
    output logic                  MemReqWrite,
    output logic [DATA_WIDTH-1:0] MemAddr,
    output logic [CNT_WIDTH-1:0]  HitCount,
    output logic [CNT_WIDTH-1:0]  MissCount,
    output logic [CNT_WIDTH-1:0]  WbCount
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMPARE   = 3'd1,
        S_WRITEBACK = 3'd2,
        S_REFILL    = 3'd3,
        S_UPDATE    = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // Only word addresses are kept; the byte-offset bits never reach memory.
    logic [DATA_WIDTH-3:0] req_word;
    logic                  req_op;      // 1 = store
    logic [DATA_WIDTH-3:0] vic_word;
    logic                  replay;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{A[1:0], VictimAddr[1:0]};

    logic req_valid;
    assign req_valid = MemRead | MemWrite;

    // State register; reset abandons any in-flight miss sequence.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; outputs are forced low while reset is held.
    always_comb begin
        next_state  = state;
        Stall       = 1'b0;
        CacheRdEn   = 1'b0;
        CacheWrEn   = 1'b0;
        CacheFill   = 1'b0;
        MemReqRead  = 1'b0;
        MemReqWrite = 1'b0;
        MemAddr     = '0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    Stall      = 1'b1;
                    next_state = S_COMPARE;
                end
            end
            S_COMPARE: begin
                CacheRdEn = 1'b1;
                if (Hit) begin
                    CacheWrEn  = req_op;
                    next_state = S_IDLE;
                end else begin
                    Stall      = 1'b1;
                    next_state = VictimDirty ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                Stall       = 1'b1;
                MemReqWrite = 1'b1;
                MemAddr     = {vic_word, 2'b00};
                if (MemReady) begin
                    next_state = S_REFILL;
                end
            end
            S_REFILL: begin
                Stall      = 1'b1;
                MemReqRead = 1'b1;
                MemAddr    = {req_word, 2'b00};
                if (MemReady) begin
                    next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                Stall      = 1'b1;
                CacheFill  = 1'b1;
                next_state = S_COMPARE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (RST) begin
            Stall       = 1'b0;
            CacheRdEn   = 1'b0;
            CacheWrEn   = 1'b0;
            CacheFill   = 1'b0;
            MemReqRead  = 1'b0;
            MemReqWrite = 1'b0;
            MemAddr     = '0;
        end
    end

    // Request/victim latches and the replay flag that marks the second lookup.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_word <= '0;
            req_op   <= 1'b0;
            vic_word <= '0;
            replay   <= 1'b0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                req_word <= A[DATA_WIDTH-1:2];
                req_op   <= MemWrite;
            end
            if (state == S_COMPARE && !Hit && VictimDirty) begin
                vic_word <= VictimAddr[DATA_WIDTH-1:2];
            end
            if (state == S_UPDATE) begin
                replay <= 1'b1;
            end else if (state == S_COMPARE && Hit) begin
                replay <= 1'b0;
            end
        end
    end

    // Saturating performance counters; replayed hits are not first-lookup hits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            HitCount  <= '0;
            MissCount <= '0;
            WbCount   <= '0;
        end else begin
            if (state == S_COMPARE && Hit && !replay && HitCount != '1) begin
                HitCount <= HitCount + 1'b1;
            end
            if (state == S_COMPARE && !Hit && MissCount != '1) begin
                MissCount <= MissCount + 1'b1;
            end
            if (state == S_WRITEBACK && MemReady && WbCount != '1) begin
                WbCount <= WbCount + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_miss_ctrl
// Brief    : Self-checking bench for cache_miss_ctrl. A transaction-level
//            model expands each access into its expected cycle timeline and
//            tracks the expected counters; a second instance with 2-bit
//            counters shares the stimulus to exercise saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_miss_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemRead, MemWrite, Hit, VictimDirty, MemReady;
    logic [31:0] A, VictimAddr;

    logic        Stall, CacheRdEn, CacheWrEn, CacheFill, MemReqRead, MemReqWrite;
    logic [31:0] MemAddr;
    logic [15:0] HitCount, MissCount, WbCount;

    logic        s_Stall, s_CacheRdEn, s_CacheWrEn, s_CacheFill, s_MemReqRead, s_MemReqWrite;
    logic [31:0] s_MemAddr;
    logic [1:0]  s_HitCount, s_MissCount, s_WbCount;

    int n_tests = 0;
    int n_fail  = 0;
    int m_hit   = 0;
    int m_miss  = 0;
    int m_wb    = 0;

    cache_miss_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .A(A),
        .Hit(Hit), .VictimDirty(VictimDirty), .VictimAddr(VictimAddr), .MemReady(MemReady),
        .Stall(Stall), .CacheRdEn(CacheRdEn), .CacheWrEn(CacheWrEn), .CacheFill(CacheFill),
        .MemReqRead(MemReqRead), .MemReqWrite(MemReqWrite), .MemAddr(MemAddr),
        .HitCount(HitCount), .MissCount(MissCount), .WbCount(WbCount)
    );

    cache_miss_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .A(A),
        .Hit(Hit), .VictimDirty(VictimDirty), .VictimAddr(VictimAddr), .MemReady(MemReady),
        .Stall(s_Stall), .CacheRdEn(s_CacheRdEn), .CacheWrEn(s_CacheWrEn), .CacheFill(s_CacheFill),
        .MemReqRead(s_MemReqRead), .MemReqWrite(s_MemReqWrite), .MemAddr(s_MemAddr),
        .HitCount(s_HitCount), .MissCount(s_MissCount), .WbCount(s_WbCount)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] sat16(input int v);
        int c;
        c = (v > 65535) ? 65535 : v;
        return c[15:0];
    endfunction

    function automatic logic [1:0] sat2(input int v);
        int c;
        c = (v > 3) ? 3 : v;
        return c[1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic cyc(input string tag, input logic stall, input logic rden, input logic wren,
                       input logic fill, input logic mrd, input logic mwr, input logic [31:0] maddr);
        #1;
        chk(tag, {26'd0, Stall, CacheRdEn, CacheWrEn, CacheFill, MemReqRead, MemReqWrite, MemAddr},
                 {26'd0, stall, rden, wren, fill, mrd, mwr, maddr});
        chk({tag, "_sat"}, {26'd0, s_Stall, s_CacheRdEn, s_CacheWrEn, s_CacheFill, s_MemReqRead,
                            s_MemReqWrite, s_MemAddr},
                           {26'd0, stall, rden, wren, fill, mrd, mwr, maddr});
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_hit"},      {48'd0, HitCount},    {48'd0, sat16(m_hit)});
        chk({tag, "_miss"},     {48'd0, MissCount},   {48'd0, sat16(m_miss)});
        chk({tag, "_wb"},       {48'd0, WbCount},     {48'd0, sat16(m_wb)});
        chk({tag, "_sat_hit"},  {62'd0, s_HitCount},  {62'd0, sat2(m_hit)});
        chk({tag, "_sat_miss"}, {62'd0, s_MissCount}, {62'd0, sat2(m_miss)});
        chk({tag, "_sat_wb"},   {62'd0, s_WbCount},   {62'd0, sat2(m_wb)});
    endtask

    // One complete CPU access, from request to the first idle cycle after it.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic hit, input logic dirty, input logic [31:0] vaddr,
                           input int wbw, input int rfw);
        logic is_wr;
        is_wr       = wr;
        MemRead     = rd;
        MemWrite    = wr;
        A           = addr;
        Hit         = 1'($urandom);
        VictimDirty = 1'($urandom);
        VictimAddr  = $urandom;
        MemReady    = 1'($urandom);
        cyc("idle_req", 1, 0, 0, 0, 0, 0, 32'd0);
        Hit         = hit;
        VictimDirty = dirty;
        VictimAddr  = vaddr;
        MemReady    = 1'($urandom);
        cyc("compare", !hit, 1, hit && is_wr, 0, 0, 0, 32'd0);
        if (hit) begin
            m_hit++;
        end else begin
            m_miss++;
            if (dirty) begin
                for (int i = 0; i < wbw; i++) begin
                    MemReady    = (i == wbw - 1);
                    Hit         = 1'($urandom);
                    VictimDirty = 1'($urandom);
                    VictimAddr  = $urandom;
                    cyc("writeback", 1, 0, 0, 0, 0, 1, {vaddr[31:2], 2'b00});
                end
                m_wb++;
            end
            for (int i = 0; i < rfw; i++) begin
                MemReady = (i == rfw - 1);
                Hit      = 1'($urandom);
                MemRead  = 1'($urandom);
                MemWrite = 1'($urandom);
                cyc("refill", 1, 0, 0, 0, 1, 0, {addr[31:2], 2'b00});
            end
            MemReady = 1'($urandom);
            Hit      = 1'($urandom);
            cyc("update", 1, 0, 0, 1, 0, 0, 32'd0);
            Hit      = 1'b1;
            MemReady = 1'($urandom);
            cyc("replay", 0, 1, is_wr, 0, 0, 0, 32'd0);
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemReady = 1'b0;
        Hit      = 1'b0;
        cyc("idle", 0, 0, 0, 0, 0, 0, 32'd0);
        check_counts("counts");
    endtask

    initial begin
        RST         = 1'b1;
        MemRead     = 1'b1;
        MemWrite    = 1'b0;
        A           = 32'h0;
        Hit         = 1'b0;
        VictimDirty = 1'b0;
        VictimAddr  = 32'h0;
        MemReady    = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        // Outputs stay low under reset even with a request pending.
        cyc("reset", 0, 0, 0, 0, 0, 0, 32'd0);
        check_counts("reset_counts");
        MemRead = 1'b0;
        RST     = 1'b0;
        cyc("post_reset", 0, 0, 0, 0, 0, 0, 32'd0);

        // Read hits; five of them drive the 2-bit counter to saturation.
        for (int i = 0; i < 5; i++) begin
            run_txn(1, 0, 32'h40, 1, 0, 32'h0, 1, 1);
        end
        chk("sat_hold", {62'd0, s_HitCount}, 64'd3);

        // Clean read miss with memory ready on the third refill cycle.
        run_txn(1, 0, 32'h40, 0, 0, 32'h0, 1, 3);
        // Dirty store miss.
        run_txn(0, 1, 32'h84, 0, 1, 32'h104, 2, 2);
        // Load and store together: treated as a store.
        run_txn(1, 1, 32'h1C3, 1, 0, 32'h0, 1, 1);

        // Stray MemReady while idle has no effect.
        MemReady = 1'b1;
        cyc("stray_ready", 0, 0, 0, 0, 0, 0, 32'd0);
        MemReady = 1'b0;
        check_counts("stray_counts");

        // Reset asserted in the middle of a refill.
        MemRead = 1'b1;
        A       = 32'h200;
        cyc("rst_idle_req", 1, 0, 0, 0, 0, 0, 32'd0);
        Hit         = 1'b0;
        VictimDirty = 1'b0;
        cyc("rst_compare", 1, 1, 0, 0, 0, 0, 32'd0);
        m_miss++;
        MemReady = 1'b0;
        cyc("rst_refill", 1, 0, 0, 0, 1, 0, 32'h200);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_async_stall", {63'd0, Stall}, 64'd0);
        chk("rst_async_memreq", {63'd0, MemReqRead}, 64'd0);
        m_hit  = 0;
        m_miss = 0;
        m_wb   = 0;
        check_counts("rst_async_counts");
        @(negedge CLK);
        MemRead = 1'b0;
        RST     = 1'b0;
        cyc("rst_release", 0, 0, 0, 0, 0, 0, 32'd0);
        run_txn(1, 0, 32'h300, 0, 0, 32'h0, 1, 2);

        // Randomized accesses.
        for (int t = 0; t < 40; t++) begin
            logic rd, wr;
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            run_txn(rd, wr, $urandom, 1'($urandom), 1'($urandom), $urandom,
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            if (($urandom % 3) == 0) begin
                MemReady = 1'($urandom);
                cyc("gap", 0, 0, 0, 0, 0, 0, 32'd0);
                MemReady = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
